trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, datapath/address width.
REQ-002 SHALL have parameter DRAIN, default 3, flush-hold cycles after a redirect (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port exceptSignal_E  input  7  execute-stage exception vector: bit0 load misalign, bit1 load access fault, bit2 store misalign, bit3 store access fault, bit4 load page fault, bit5 store page fault, bit6 breakpoint.
REQ-006 SHALL have port valid_E  input  1  execute-stage instruction valid.
REQ-007 SHALL have ports PC_E and DM_addr_E  input  N  PC and data address of the execute-stage instruction.
REQ-008 SHALL have port mret_E  input  1  execute-stage instruction is MRET.
REQ-009 SHALL have ports csr_we (input, 1), csr_addr (input, 2; 0 mtvec, 1 mepc, 2 mcause, 3 mtval), csr_wdata (input, N), csr_rdata (output, N, combinational read).
REQ-010 SHALL have ports flush (output, 1), redirect_valid (output, 1), redirect_PC (output, N), busy (output, 1).

Function
REQ-011 SHALL implement FSM states IDLE, TRAP, RET, DRAIN.
REQ-012 In IDLE, valid_E=1 with exceptSignal_E nonzero SHALL capture mepc/mcause/mtval on that edge and move to TRAP.
REQ-013 Priority SHALL be bit6 > bit2 > bit0 > bit5 > bit4 > bit3 > bit1; only the winner is recorded.
REQ-014 mcause SHALL be zero-extended code: bit6=3, bit0=4, bit1=5, bit2=6, bit3=7, bit4=13, bit5=15.
REQ-015 mtval SHALL be PC_E for breakpoint, DM_addr_E otherwise.
REQ-016 In IDLE, valid_E=1, mret_E=1, exceptSignal_E=0 SHALL move to RET; exception and MRET together -> exception wins.
REQ-017 TRAP (one cycle): flush=1, redirect_valid=1, redirect_PC = mtvec with bits[1:0] forced 0; next DRAIN.
REQ-018 RET (one cycle): flush=1, redirect_valid=1, redirect_PC = mepc; next DRAIN.
REQ-019 DRAIN: flush=1, redirect_valid=0 for exactly DRAIN cycles via down-counter, then IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Exceptions and MRET arriving outside IDLE SHALL be ignored (no capture, no state change).
REQ-022 valid_E=0 SHALL suppress all detection regardless of exceptSignal_E.
REQ-023 CSR write SHALL take effect on the next edge; same-edge trap capture overrides the write for mepc/mcause/mtval; mtvec writes always apply.
REQ-024 A write to mepc in the same cycle an MRET is accepted SHALL be visible in RET's redirect_PC.
REQ-025 mepc SHALL store bits[1:0] as 0 on both capture and CSR write.

Reset
REQ-026 reset=0 at an edge SHALL force IDLE, counter 0, mtvec/mepc/mcause/mtval to 0, overriding any in-progress TRAP/RET/DRAIN.
REQ-027 Outputs after reset: flush=0, redirect_valid=0, redirect_PC=0, busy=0.
REQ-028 Inputs SHALL be ignored in any cycle where reset=0.

Configuration
REQ-029 Macro TRAP_MTVAL_EN: when defined, mtval behaves per REQ-015/REQ-023.
REQ-030 When TRAP_MTVAL_EN undefined, mtval SHALL not be implemented, reads return 0, and writes are discarded.

Verification
REQ-031 mtvec=0x100 written; valid_E=1, exceptSignal_E=7'h01, DM_addr_E=0x1003, PC_E=0x40 -> next cycle flush=1, redirect_PC=0x100; mcause=4, mepc=0x40, mtval=0x1003; flush held 3 further cycles, then busy=0.
REQ-032 exceptSignal_E=7'h45, PC_E=0x80 -> mcause=3, mtval=0x80 (breakpoint wins).
REQ-033 After REQ-031 trap, MRET in IDLE -> redirect_PC=0x40, mepc unchanged; MRET with exceptSignal_E=7'h04 -> trap taken, mcause=6.
REQ-034 Exception 7'h02 during DRAIN -> ignored: mcause stays, no extra flush cycles.
REQ-035 reset=0 in TRAP cycle -> next cycle all outputs and CSRs 0, state IDLE.
REQ-036 TRAP_MTVAL_EN undefined, REQ-031 stimulus -> csr_rdata for addr 3 is 0.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/return controller: captures exceptions, redirects to mtvec or mepc, drains the pipe.
// Optional TRAP_MTVAL_EN implements the mtval register; without it mtval reads as 0.
module trap_ctrl #(
  parameter int N     = 64,
  parameter int DRAIN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [6:0]   exceptSignal_E,
  input  logic         valid_E,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] DM_addr_E,
  input  logic         mret_E,
  input  logic         csr_we,
  input  logic [1:0]   csr_addr,
  input  logic [N-1:0] csr_wdata,
  output logic [N-1:0] csr_rdata,
  output logic         flush,
  output logic         redirect_valid,
  output logic [N-1:0] redirect_PC,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP,
    S_RET,
    S_DRAIN
  } state_t;

  localparam logic [3:0]   DRAIN_LD = 4'(DRAIN - 1);
  localparam logic [N-1:0] ALIGN    = ~N'(3);

  state_t       state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic [N-1:0] mtvec, mepc, mcause;
  logic         take_exc, take_ret, cap;
  logic [3:0]   code;

  assign take_exc = valid_E && (exceptSignal_E != 7'd0);
  assign take_ret = valid_E && mret_E && (exceptSignal_E == 7'd0);
  assign cap      = (state == S_IDLE) && take_exc;

  // Fixed priority: bkpt > st misalign > ld misalign > st pf > ld pf > st af > ld af
  always_comb begin
    code = 4'd0;
    if (exceptSignal_E[6])      code = 4'd3;
    else if (exceptSignal_E[2]) code = 4'd6;
    else if (exceptSignal_E[0]) code = 4'd4;
    else if (exceptSignal_E[5]) code = 4'd15;
    else if (exceptSignal_E[4]) code = 4'd13;
    else if (exceptSignal_E[3]) code = 4'd7;
    else if (exceptSignal_E[1]) code = 4'd5;
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_PC    = '0;
    busy           = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (take_exc)      state_n = S_TRAP;
        else if (take_ret) state_n = S_RET;
      end
      S_TRAP: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_PC    = mtvec & ALIGN;
        state_n        = S_DRAIN;
        cnt_n          = DRAIN_LD;
      end
      S_RET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_PC    = mepc;
        state_n        = S_DRAIN;
        cnt_n          = DRAIN_LD;
      end
      S_DRAIN: begin
        flush = 1'b1;
        if (cnt == 4'd0) state_n = S_IDLE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mtvec  <= '0;
      mepc   <= '0;
      mcause <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (csr_we && csr_addr == 2'd0) mtvec <= csr_wdata;
      if (cap) begin
        mepc   <= PC_E & ALIGN;
        mcause <= N'(code);
      end else if (csr_we) begin
        if (csr_addr == 2'd1) mepc   <= csr_wdata & ALIGN;
        if (csr_addr == 2'd2) mcause <= csr_wdata;
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [N-1:0] mtval;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtval <= '0;
    end else if (cap) begin
      mtval <= exceptSignal_E[6] ? PC_E : DM_addr_E;
    end else if (csr_we && csr_addr == 2'd3) begin
      mtval <= csr_wdata;
    end
  end
`else
  logic [N-1:0] mtval;
  logic         unused_dm;
  assign mtval     = '0;
  assign unused_dm = ^DM_addr_E;
`endif

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      2'd0:    csr_rdata = mtvec;
      2'd1:    csr_rdata = mepc;
      2'd2:    csr_rdata = mcause;
      2'd3:    csr_rdata = mtval;
      default: csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, priority, MRET, drain, CSR rules, reset.
module tb_trap_ctrl;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   exc;
  logic         valid;
  logic [N-1:0] pc, dm;
  logic         mret;
  logic         we;
  logic [1:0]   addr;
  logic [N-1:0] wdata, rdata;
  logic         flush, rv, busy;
  logic [N-1:0] rpc;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(.N(N), .DRAIN(3)) dut (
    .clk(clk), .reset(reset), .exceptSignal_E(exc), .valid_E(valid),
    .PC_E(pc), .DM_addr_E(dm), .mret_E(mret), .csr_we(we),
    .csr_addr(addr), .csr_wdata(wdata), .csr_rdata(rdata),
    .flush(flush), .redirect_valid(rv), .redirect_PC(rpc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mtval_exp(input logic [N-1:0] v);
`ifdef TRAP_MTVAL_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [N-1:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic idle_in();
    exc = '0; valid = 0; mret = 0; we = 0; wdata = '0; pc = '0; dm = '0;
  endtask

  task automatic test_reset();
    logic [N-1:0] v;
    idle_in();
    reset = 0;
    step(); step();
    reset = 1;
    checks++; if ({flush, rv, busy} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl got %b exp 000", {flush, rv, busy}); end
    checks++; if (rpc !== '0) begin errors++;
      $display("FAIL reset_rpc got %h exp 0", rpc); end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      checks++; if (v !== '0) begin errors++;
        $display("FAIL reset_csr%0d got %h exp 0", i, v); end
    end
  endtask

  task automatic test_basic_trap();
    logic [N-1:0] v;
    we = 1; addr = 0; wdata = 64'h100;
    step();
    we = 0;
    valid = 1; exc = 7'h01; dm = 64'h1003; pc = 64'h40;
    step();
    idle_in();
    checks++; if ({flush, rv, busy} !== 3'b111 || rpc !== 64'h100) begin errors++;
      $display("FAIL trap_redirect got %b %h exp 111 100", {flush, rv, busy}, rpc); end
    rd(2, v);
    checks++; if (v !== 64'd4) begin errors++;
      $display("FAIL trap_mcause got %h exp 4", v); end
    rd(1, v);
    checks++; if (v !== 64'h40) begin errors++;
      $display("FAIL trap_mepc got %h exp 40", v); end
    rd(3, v);
    checks++; if (v !== mtval_exp(64'h1003)) begin errors++;
      $display("FAIL trap_mtval got %h exp %h", v, mtval_exp(64'h1003)); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({flush, rv, busy} !== 3'b101) begin errors++;
        $display("FAIL drain%0d got %b exp 101", i, {flush, rv, busy}); end
    end
    step();
    checks++; if ({flush, rv, busy} !== 3'b000) begin errors++;
      $display("FAIL drain_end got %b exp 000", {flush, rv, busy}); end
  endtask

  task automatic test_mret();
    logic [N-1:0] v;
    valid = 1; mret = 1;
    step();
    idle_in();
    checks++; if ({flush, rv, busy} !== 3'b111 || rpc !== 64'h40) begin errors++;
      $display("FAIL mret_redirect got %b %h exp 111 40", {flush, rv, busy}, rpc); end
    rd(1, v);
    checks++; if (v !== 64'h40) begin errors++;
      $display("FAIL mret_mepc got %h exp 40", v); end
    step(); step(); step(); step();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL mret_done busy got %b exp 0", busy); end
    valid = 1; mret = 1; exc = 7'h04; pc = 64'h50; dm = 64'h3000;
    step();
    idle_in();
    checks++; if (rpc !== 64'h100) begin errors++;
      $display("FAIL mret_exc_rpc got %h exp 100", rpc); end
    rd(2, v);
    checks++; if (v !== 64'd6) begin errors++;
      $display("FAIL mret_exc_mcause got %h exp 6", v); end
    rd(1, v);
    checks++; if (v !== 64'h50) begin errors++;
      $display("FAIL mret_exc_mepc got %h exp 50", v); end
    step(); step(); step(); step();
  endtask

  task automatic test_priority();
    logic [N-1:0] v;
    logic [6:0]   vec [6] = '{7'h45, 7'h30, 7'h18, 7'h0A, 7'h02, 7'h05};
    logic [3:0]   cause [6] = '{4'd3, 4'd15, 4'd13, 4'd7, 4'd5, 4'd6};
    for (int i = 0; i < 6; i++) begin
      valid = 1; exc = vec[i]; pc = 64'h80; dm = 64'h2000 + 64'(i);
      step();
      idle_in();
      rd(2, v);
      checks++; if (v !== 64'(cause[i])) begin errors++;
        $display("FAIL prio_%h got %0d exp %0d", vec[i], v, cause[i]); end
      rd(3, v);
      if (i == 0) begin
        checks++; if (v !== mtval_exp(64'h80)) begin errors++;
          $display("FAIL bkpt_mtval got %h exp %h", v, mtval_exp(64'h80)); end
      end else begin
        checks++; if (v !== mtval_exp(64'h2000 + 64'(i))) begin errors++;
          $display("FAIL prio_mtval%0d got %h", i, v); end
      end
      step(); step(); step(); step();
    end
  endtask

  task automatic test_drain_ignore();
    logic [N-1:0] v;
    valid = 1; exc = 7'h01; pc = 64'h60; dm = 64'h10;
    step();
    idle_in();
    step();
    valid = 1; exc = 7'h02; pc = 64'h64; dm = 64'h20;
    step();
    idle_in();
    rd(2, v);
    checks++; if (v !== 64'd4) begin errors++;
      $display("FAIL drain_ign_mcause got %h exp 4", v); end
    step();
    checks++; if (flush !== 1'b1) begin errors++;
      $display("FAIL drain_ign_last got %b exp 1", flush); end
    step();
    checks++; if ({flush, busy} !== 2'b00) begin errors++;
      $display("FAIL drain_ign_end got %b exp 00", {flush, busy}); end
    valid = 0; exc = 7'h7F; mret = 1;
    step();
    idle_in();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL invalid_suppress busy got %b exp 0", busy); end
  endtask

  task automatic test_csr_rules();
    logic [N-1:0] v;
    valid = 1; mret = 1; we = 1; addr = 1; wdata = 64'h207;
    step();
    idle_in();
    checks++; if (rpc !== 64'h204) begin errors++;
      $display("FAIL mret_wr_mepc got %h exp 204", rpc); end
    step(); step(); step(); step();
    valid = 1; exc = 7'h01; pc = 64'h70; dm = 64'h30;
    we = 1; addr = 2; wdata = 64'h55;
    step();
    idle_in();
    rd(2, v);
    checks++; if (v !== 64'd4) begin errors++;
      $display("FAIL cap_over_wr got %h exp 4", v); end
    step(); step(); step(); step();
    valid = 1; exc = 7'h01; we = 1; addr = 0; wdata = 64'h203;
    step();
    idle_in();
    checks++; if (rpc !== 64'h200) begin errors++;
      $display("FAIL mtvec_same_edge got %h exp 200", rpc); end
    step(); step(); step(); step();
    we = 1; addr = 3; wdata = 64'h777;
    step();
    we = 0;
    rd(3, v);
    checks++; if (v !== mtval_exp(64'h777)) begin errors++;
      $display("FAIL mtval_wr got %h exp %h", v, mtval_exp(64'h777)); end
    we = 1; addr = 1; wdata = 64'h12B;
    step();
    we = 0;
    rd(1, v);
    checks++; if (v !== 64'h128) begin errors++;
      $display("FAIL mepc_align got %h exp 128", v); end
  endtask

  task automatic test_reset_in_trap();
    logic [N-1:0] v;
    valid = 1; exc = 7'h01; pc = 64'h40; dm = 64'h1003;
    step();
    idle_in();
    reset = 0;
    valid = 1; exc = 7'h40; mret = 1; we = 1; addr = 0; wdata = 64'hABC;
    step();
    idle_in();
    reset = 1;
    checks++; if ({flush, rv, busy} !== 3'b000 || rpc !== '0) begin errors++;
      $display("FAIL rst_trap_out got %b %h exp 000 0", {flush, rv, busy}, rpc); end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      checks++; if (v !== '0) begin errors++;
        $display("FAIL rst_trap_csr%0d got %h exp 0", i, v); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_trap_idle busy got %b exp 0", busy); end
  endtask

  initial begin
    addr = 0;
    test_reset();
    test_basic_trap();
    test_mret();
    test_priority();
    test_drain_ignore();
    test_csr_rules();
    test_reset_in_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
